// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared encodings for the load/store unit (sizes, errors, states)
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // funct3 access-size encodings
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // completion status reported alongside resp_valid_o
    localparam logic [1:0] LSU_OK       = 2'b00;
    localparam logic [1:0] LSU_MISALIGN = 2'b01;
    localparam logic [1:0] LSU_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Combinational alignment check, store lane placement and load
//             byte/half extraction with sign/zero extension
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      size_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic            misalign_o,
    output logic [3:0]      wstrb_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        misalign_o = 1'b0;
        wstrb_o    = 4'b1111;
        wdata_o    = wdata_i;
        unique case (size_i)
            LSU_B, LSU_BU: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            LSU_H, LSU_HU: begin
                misalign_o = addr_lo_i[0];
                wstrb_o    = 4'b0011 << addr_lo_i;
                wdata_o    = {2{wdata_i[15:0]}};
            end
            // word and unassigned encodings are treated as full-word accesses
            default: misalign_o = |addr_lo_i;
        endcase
    end

    always_comb begin
        byte_sel = rdata_i[7:0];
        unique case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        unique case (size_i)
            LSU_B:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
            LSU_BU:  rdata_o = {24'd0, byte_sel};
            LSU_H:   rdata_o = {{16{half_sel[15]}}, half_sel};
            LSU_HU:  rdata_o = {16'd0, half_sel};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module   : lsu
//  Purpose  : Single-outstanding load/store unit with valid/ready memory port,
//             byte strobes, load extension and response timeout
//  Revision : 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            wen_i,
    input  logic            ren_i,
    input  logic [2:0]      size_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] rdata_o,
    output logic [1:0]      err_o,
    output logic            mem_valid_o,
    input  logic            mem_ready_i,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            mem_wen_o,
    output logic [3:0]      mem_wstrb_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic              mem_wen_q, mem_wen_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;

    logic              accept;
    logic              timeout_hit;
    logic [2:0]        align_size;
    logic [1:0]        align_addr_lo;
    logic              align_misalign;
    logic [3:0]        align_wstrb;
    logic [XLEN-1:0]   align_wdata;
    logic [XLEN-1:0]   align_rdata;

    // One align unit serves both phases: live request fields in IDLE for the
    // misalign/lane check, latched fields afterwards for load extraction.
    assign align_size    = (state_q == ST_IDLE) ? size_i      : size_q;
    assign align_addr_lo = (state_q == ST_IDLE) ? addr_i[1:0] : addr_lo_q;

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .size_i     (align_size),
        .addr_lo_i  (align_addr_lo),
        .wdata_i    (wdata_i),
        .rdata_i    (mem_rdata_i),
        .misalign_o (align_misalign),
        .wstrb_o    (align_wstrb),
        .wdata_o    (align_wdata),
        .rdata_o    (align_rdata)
    );

    assign accept      = req_valid_i && (wen_i || ren_i);
    assign timeout_hit = (cnt_q >= CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        addr_lo_d   = addr_lo_q;
        mem_addr_d  = mem_addr_q;
        mem_wen_d   = mem_wen_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    size_d    = size_i;
                    addr_lo_d = addr_i[1:0];
                    rdata_d   = '0;
                    if (align_misalign) begin
                        state_d = ST_RESP;
                        err_d   = LSU_MISALIGN;
                    end else begin
                        state_d     = ST_REQ;
                        err_d       = LSU_OK;
                        mem_addr_d  = {addr_i[XLEN-1:2], 2'b00};
                        mem_wen_d   = wen_i;
                        mem_wstrb_d = wen_i ? align_wstrb : 4'b0000;
                        mem_wdata_d = wen_i ? align_wdata : '0;
                    end
                end
            end

            ST_REQ: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                // a handshake on the last counted cycle still proceeds to WAIT
                if (mem_ready_i) begin
                    state_d = ST_WAIT;
                end else if (timeout_hit) begin
                    state_d = ST_RESP;
                    err_d   = LSU_TIMEOUT;
                end
            end

            ST_WAIT: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                if (mem_rvalid_i) begin
                    state_d = ST_RESP;
                    err_d   = LSU_OK;
                    rdata_d = mem_wen_q ? '0 : align_rdata;
                end else if (timeout_hit) begin
                    state_d = ST_RESP;
                    err_d   = LSU_TIMEOUT;
                    rdata_d = '0;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                rdata_d = '0;
                err_d   = LSU_OK;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            size_q      <= 3'b000;
            addr_lo_q   <= 2'b00;
            mem_addr_q  <= '0;
            mem_wen_q   <= 1'b0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= LSU_OK;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            addr_lo_q   <= addr_lo_d;
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_RESP);
    assign mem_valid_o  = (state_q == ST_REQ);
    assign mem_addr_o   = mem_addr_q;
    assign mem_wen_o    = mem_wen_q;
    assign mem_wstrb_o  = mem_wstrb_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign rdata_o      = rdata_q;
    assign err_o        = err_q;

endmodule : lsu
`default_nettype wire
